packetizer_deadlock_monitor: RTL and testbench

Parametrised deadlock monitor for the photon FIFO packetizer dataflow region. It watches N AXI-Stream block indicators and M process-instance idle/block indicators, and qualifies a deadlock candidate only after it persists for a programmable number of consecutive cycles. It then reports a live `block` flag, a sticky flag, a captured source vector and a saturating event count. It instantiates once per dataflow region and feeds the debug/status register bank.

---
 rtl/packetizer_deadlock_monitor_if.sv | 27 ++
 rtl/packetizer_deadlock_monitor.sv | 104 ++++++++++
 tb/tb_packetizer_deadlock_monitor.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/packetizer_deadlock_monitor_if.sv
// Stream/instance block indicators and status outputs of one packetizer deadlock monitor.
// The master side drives the indicators and control; the slave side is the monitor itself.
interface packetizer_deadlock_monitor_if #(
    parameter int unsigned N_AXIS = 1,
    parameter int unsigned N_INST = 1,
    parameter int unsigned EVT_W  = 16
);
    logic [N_AXIS-1:0]        axis_block_sigs;
    logic [N_INST-1:0]        inst_idle_sigs;
    logic [N_INST-1:0]        inst_block_sigs;
    logic                     enable;
    logic                     clear;
    logic                     block;
    logic                     block_sticky;
    logic [N_AXIS+N_INST-1:0] block_src;
    logic [EVT_W-1:0]         event_count;

    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs, enable, clear,
        input  block, block_sticky, block_src, event_count
    );

    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, enable, clear,
        output block, block_sticky, block_src, event_count
    );
endinterface

// File: rtl/packetizer_deadlock_monitor.sv
// Qualifies a dataflow deadlock candidate after HOLD_CYCLES consecutive cycles and reports
// live/sticky status, the source vector seen at entry, and a saturating entry count.
module packetizer_deadlock_monitor #(
    parameter int unsigned N_AXIS      = 1,
    parameter int unsigned N_INST      = 1,
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned EVT_W       = 16
) (
    input logic                         clock,
    input logic                         reset,
    packetizer_deadlock_monitor_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StArming, StBlocked} state_t;

    localparam logic [CNT_W-1:0] HoldM1 = CNT_W'(HOLD_CYCLES - 1);

    state_t                   r_state;
    state_t                   w_state_d;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_d;
    logic                     r_block;
    logic                     r_sticky;
    logic [N_AXIS+N_INST-1:0] r_src;
    logic [EVT_W-1:0]         r_evt;
    logic                     w_cand;
    logic                     w_entry;
    logic [EVT_W-1:0]         w_evt_inc;

    // All-idle never counts: the instance term needs at least one blocked instance.
    assign w_cand = (|bus.axis_block_sigs)
                  | ((&(bus.inst_idle_sigs | bus.inst_block_sigs)) & (|bus.inst_block_sigs));

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                if (bus.enable && w_cand) begin
                    if (HOLD_CYCLES == 1) begin
                        w_state_d = StBlocked;
                    end else begin
                        w_state_d = StArming;
                        w_cnt_d   = CNT_W'(1);
                    end
                end
            end
            StArming: begin
                if (!bus.enable || !w_cand) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else if (r_cnt == HoldM1) begin
                    w_state_d = StBlocked;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            StBlocked: begin
                if (!bus.enable || !w_cand) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    assign w_entry   = (r_state != StBlocked) && (w_state_d == StBlocked);
    assign w_evt_inc = (&r_evt) ? r_evt : r_evt + EVT_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_block  <= 1'b0;
            r_sticky <= 1'b0;
            r_src    <= '0;
            r_evt    <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_block <= (w_state_d == StBlocked);
            // An entry in the same cycle as clear wins and restarts the count at one.
            if (w_entry) begin
                r_sticky <= 1'b1;
                r_src    <= {bus.inst_block_sigs, bus.axis_block_sigs};
                r_evt    <= bus.clear ? EVT_W'(1) : w_evt_inc;
            end else if (bus.clear) begin
                r_sticky <= 1'b0;
                r_src    <= '0;
                r_evt    <= '0;
            end
        end
    end

    assign bus.block        = r_block;
    assign bus.block_sticky = r_sticky;
    assign bus.block_src    = r_src;
    assign bus.event_count  = r_evt;
endmodule

// File: tb/tb_packetizer_deadlock_monitor.sv
// Directed bench for the deadlock monitor: one instance with HOLD_CYCLES=1 and a 3-bit event
// counter, one with HOLD_CYCLES=8.
module tb_packetizer_deadlock_monitor;
    logic clock;
    logic rst1;
    logic rst8;
    int   n_checks;
    int   n_pass;

    packetizer_deadlock_monitor_if #(.N_AXIS(2), .N_INST(3), .EVT_W(3))  b1 ();
    packetizer_deadlock_monitor_if #(.N_AXIS(2), .N_INST(3), .EVT_W(16)) b8 ();

    packetizer_deadlock_monitor #(
        .N_AXIS(2), .N_INST(3), .HOLD_CYCLES(1), .CNT_W(16), .EVT_W(3)
    ) dut1 (
        .clock(clock),
        .reset(rst1),
        .bus  (b1.slave)
    );

    packetizer_deadlock_monitor #(
        .N_AXIS(2), .N_INST(3), .HOLD_CYCLES(8), .CNT_W(16), .EVT_W(16)
    ) dut8 (
        .clock(clock),
        .reset(rst8),
        .bus  (b8.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pulse1(input logic [1:0] axis);
        b1.axis_block_sigs = axis;
        tick();
        b1.axis_block_sigs = 2'b00;
        tick();
    endtask

    task automatic cand8(input logic on);
        b8.inst_block_sigs = on ? 3'b001 : 3'b000;
        b8.inst_idle_sigs  = on ? 3'b110 : 3'b000;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst1 = 1'b1;
        rst8 = 1'b1;
        b1.axis_block_sigs = '0; b1.inst_idle_sigs = '0; b1.inst_block_sigs = '0;
        b1.enable = 1'b1; b1.clear = 1'b0;
        b8.axis_block_sigs = '0; b8.inst_idle_sigs = '0; b8.inst_block_sigs = '0;
        b8.enable = 1'b1; b8.clear = 1'b0;
        tick();
        tick();
        rst1 = 1'b0;
        rst8 = 1'b0;

        // Reset values
        check("rst_block",  32'(b1.block),        32'd0);
        check("rst_sticky", 32'(b1.block_sticky), 32'd0);
        check("rst_src",    32'(b1.block_src),    32'd0);
        check("rst_evt",    32'(b1.event_count),  32'd0);
        check("rst8_block", 32'(b8.block),        32'd0);

        // Basic qualification, HOLD_CYCLES=1
        b1.axis_block_sigs = 2'b10;
        tick();
        check("basic_block",  32'(b1.block),        32'd1);
        check("basic_src",    32'(b1.block_src),    32'b00010);
        check("basic_evt",    32'(b1.event_count),  32'd1);
        check("basic_sticky", 32'(b1.block_sticky), 32'd1);
        b1.axis_block_sigs = 2'b00;
        tick();
        check("basic_fall",   32'(b1.block),        32'd0);
        check("basic_hold",   32'(b1.block_sticky), 32'd1);

        for (int i = 0; i < 4; i++) pulse1(2'b01);
        check("evt_five", 32'(b1.event_count), 32'd5);
        check("src_last", 32'(b1.block_src),   32'b00001);

        // Clear coinciding with an entry
        b1.inst_block_sigs = 3'b010;
        b1.inst_idle_sigs  = 3'b101;
        b1.clear = 1'b1;
        tick();
        b1.clear = 1'b0;
        check("coll_sticky", 32'(b1.block_sticky), 32'd1);
        check("coll_evt",    32'(b1.event_count),  32'd1);
        check("coll_src",    32'(b1.block_src),    32'b01000);
        tick();
        check("coll_stay",   32'(b1.event_count),  32'd1);

        // Lone clear while blocked
        b1.clear = 1'b1;
        tick();
        b1.clear = 1'b0;
        check("clr_sticky", 32'(b1.block_sticky), 32'd0);
        check("clr_src",    32'(b1.block_src),    32'd0);
        check("clr_evt",    32'(b1.event_count),  32'd0);
        check("clr_block",  32'(b1.block),        32'd1);

        // Enable drop while blocked: re-enter first so sticky is set
        b1.inst_block_sigs = 3'b000;
        b1.inst_idle_sigs  = 3'b000;
        tick();
        check("re_idle", 32'(b1.block), 32'd0);
        b1.axis_block_sigs = 2'b11;
        tick();
        check("re_block", 32'(b1.block), 32'd1);
        b1.enable = 1'b0;
        tick();
        check("en_block",  32'(b1.block),        32'd0);
        check("en_sticky", 32'(b1.block_sticky), 32'd1);
        check("en_evt",    32'(b1.event_count),  32'd1);
        check("en_src",    32'(b1.block_src),    32'b00011);
        tick();
        check("en_stay",   32'(b1.block),        32'd0);
        b1.axis_block_sigs = 2'b00;
        b1.enable = 1'b1;

        // Saturation: 2^3+3 entries after a clear
        b1.clear = 1'b1;
        tick();
        b1.clear = 1'b0;
        check("sat_clr", 32'(b1.event_count), 32'd0);
        for (int i = 0; i < 11; i++) pulse1(2'b10);
        check("sat_evt", 32'(b1.event_count), 32'd7);

        // All-idle exclusion
        b1.clear = 1'b1;
        tick();
        b1.clear = 1'b0;
        b1.inst_idle_sigs  = 3'b111;
        b1.inst_block_sigs = 3'b000;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_block", 32'(b1.block), 32'd0);
        end
        check("idle_evt", 32'(b1.event_count), 32'd0);
        b1.inst_idle_sigs = 3'b000;

        // Persistence, HOLD_CYCLES=8: 7 cycles is not enough
        cand8(1'b1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("p7_block", 32'(b8.block), 32'd0);
        end
        cand8(1'b0);
        tick();
        check("p7_after", 32'(b8.block), 32'd0);
        check("p7_evt",   32'(b8.event_count), 32'd0);

        // 8 consecutive cycles
        cand8(1'b1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("p8_pre", 32'(b8.block), 32'd0);
        end
        tick();
        check("p8_block", 32'(b8.block),        32'd1);
        check("p8_evt",   32'(b8.event_count),  32'd1);
        check("p8_src",   32'(b8.block_src),    32'b00100);
        check("p8_stk",   32'(b8.block_sticky), 32'd1);
        cand8(1'b0);
        tick();
        check("p8_fall",  32'(b8.block), 32'd0);

        // One-cycle gap at cycle 5 restarts the count
        cand8(1'b1);
        for (int i = 0; i < 4; i++) tick();
        cand8(1'b0);
        tick();
        cand8(1'b1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("gap_pre", 32'(b8.block), 32'd0);
        end
        tick();
        check("gap_block", 32'(b8.block),       32'd1);
        check("gap_evt",   32'(b8.event_count), 32'd2);
        cand8(1'b0);
        tick();

        // Reset during ARMING, with clear and enable asserted
        cand8(1'b1);
        for (int i = 0; i < 3; i++) tick();
        rst8 = 1'b1;
        b8.clear = 1'b1;
        tick();
        check("rarm_block",  32'(b8.block),        32'd0);
        check("rarm_sticky", 32'(b8.block_sticky), 32'd0);
        check("rarm_src",    32'(b8.block_src),    32'd0);
        check("rarm_evt",    32'(b8.event_count),  32'd0);
        rst8 = 1'b0;
        b8.clear = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("rarm_pre", 32'(b8.block), 32'd0);
        end
        tick();
        check("rarm_block2", 32'(b8.block),       32'd1);
        check("rarm_evt2",   32'(b8.event_count), 32'd1);
        cand8(1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
